// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: NOP encodings, control-word field layout and per-stage bubble constants.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int CTRL_W_DEFAULT = 16;

    // Control-word layout, low bit first; bit 15 is spare.
    localparam int ALUSRCA_OFS  = 0;
    localparam int ALUSRCA_W    = 1;
    localparam int ALUSRCB_OFS  = 1;
    localparam int ALUSRCB_W    = 1;
    localparam int WBSEL_OFS    = 2;
    localparam int WBSEL_W      = 2;
    localparam int IMMSEL_OFS   = 4;
    localparam int IMMSEL_W     = 3;
    localparam int MEMWREN_OFS  = 7;
    localparam int MEMWREN_W    = 1;
    localparam int REGWREN_OFS  = 8;
    localparam int REGWREN_W    = 1;
    localparam int LOADTYPE_OFS = 9;
    localparam int LOADTYPE_W   = 3;
    localparam int MEMSIZE_OFS  = 12;
    localparam int MEMSIZE_W    = 2;
    localparam int HALT_OFS     = 14;
    localparam int HALT_W       = 1;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wbsel_e;

    localparam logic [CTRL_W_DEFAULT-1:0] NOP_CTRL_ID  = '0;
    localparam logic [CTRL_W_DEFAULT-1:0] NOP_CTRL_EX  = '0;
    localparam logic [CTRL_W_DEFAULT-1:0] NOP_CTRL_MEM = '0;
    localparam logic [CTRL_W_DEFAULT-1:0] NOP_CTRL_WB  = '0;

    // A bubble must never write the register file or memory.
    function automatic logic ctrlIsSafeNop(input logic [CTRL_W_DEFAULT-1:0] ctrl);
        return !ctrl[MEMWREN_OFS] && !ctrl[REGWREN_OFS];
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload+valid register; clear wins over load and returns the payload to its bubble value.
module pipe_slot #(
    parameter int W = 48,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(negedge CLK) begin
        if (RST || i_clear) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with optional skid slot, flush-to-bubble, NEW flag and stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter logic [DATA_W-1:0] NOP_DATA = DATA_W'(NOP_INSTR),
    parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
    parameter int SKID = 1,
    parameter int CNT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_bubble,
    output logic              NEW,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int SLOT_W = DATA_W + CTRL_W;
    localparam logic [SLOT_W-1:0] NOP_SLOT = {NOP_DATA, NOP_CTRL};

    logic              w_mainValid;
    logic              w_skidValid;
    logic [SLOT_W-1:0] w_mainData;
    logic [SLOT_W-1:0] w_skidData;
    logic [SLOT_W-1:0] w_mainNext;
    logic              w_inReady;
    logic              w_accIn;
    logic              w_accOut;
    logic              w_mainLoad;
    logic              w_mainClear;
    logic              w_skidLoad;
    logic              w_skidClear;

    logic              r_new;
    logic [CNT_W-1:0]  r_stallCnt;

    // The skid entry is always older than anything upstream, so it refills main first.
    always_comb begin
        w_inReady   = (SKID != 0) ? !w_skidValid : (!w_mainValid || out_ready);
        w_accIn     = in_valid && w_inReady;
        w_accOut    = w_mainValid && out_ready;
        w_mainLoad  = !flush && ((w_skidValid && out_ready) ||
                                 (w_accIn && (!w_mainValid || out_ready)));
        w_mainNext  = w_skidValid ? w_skidData : {in_data, in_ctrl};
        w_mainClear = flush || (w_accOut && !w_mainLoad);
        w_skidLoad  = !flush && w_accIn && w_mainValid && !out_ready;
        w_skidClear = flush || (w_skidValid && out_ready);
    end

    pipe_slot #(.W(SLOT_W), .RESET_VAL(NOP_SLOT)) u_main (
        .CLK     (CLK),
        .RST     (RST),
        .i_load  (w_mainLoad),
        .i_clear (w_mainClear),
        .i_data  (w_mainNext),
        .o_valid (w_mainValid),
        .o_data  (w_mainData)
    );

    if (SKID != 0) begin : g_skid
        pipe_slot #(.W(SLOT_W), .RESET_VAL(NOP_SLOT)) u_skid (
            .CLK     (CLK),
            .RST     (RST),
            .i_load  (w_skidLoad),
            .i_clear (w_skidClear),
            .i_data  ({in_data, in_ctrl}),
            .o_valid (w_skidValid),
            .o_data  (w_skidData)
        );
    end else begin : g_noSkid
        assign w_skidValid = 1'b0;
        assign w_skidData  = NOP_SLOT;
    end

    // NEW drops on any accepted input, even one a flush then discards.
    always_ff @(negedge CLK) begin
        if (RST) begin
            r_new      <= 1'b1;
            r_stallCnt <= '0;
        end else begin
            if (w_accIn)
                r_new <= 1'b0;
            if (in_valid && !w_inReady && (r_stallCnt != {CNT_W{1'b1}}))
                r_stallCnt <= r_stallCnt + CNT_W'(1);
        end
    end

    assign in_ready   = w_inReady;
    assign out_valid  = w_mainValid;
    assign out_data   = w_mainData[SLOT_W-1:CTRL_W];
    assign out_ctrl   = w_mainData[CTRL_W-1:0];
    assign out_bubble = !w_mainValid;
    assign occupancy  = {1'b0, w_mainValid} + {1'b0, w_skidValid};
    assign NEW        = r_new;
    assign stall_cnt  = r_stallCnt;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline-stage register that replaces the per-stage hand-written data/ctrl register pairs between IF/ID/EX/MEM/WB.
- Carries a generic data word and a generic control word.
- Stall handling is a valid/ready handshake, with an optional 2-entry skid slot to break the ready path.
- Flush inserts a NOP bubble; a NEW flag and a saturating stall counter are exported for the hazard unit and debug.

Parameters:
- DATA_W, 32, width of the data payload (InstWord, PC, operands concatenated by the instantiating stage).
- CTRL_W, 16, width of the control payload.
- NOP_DATA, 32'h00000013, data value presented while the stage holds a bubble (addi x0,x0,0 in the low 32 bits, zero-extended).
- NOP_CTRL, 0, control value presented while holding a bubble; must encode RegWrEn=0 and MemWrEn=0.
- SKID, 1, 0 = single slot (ready combinationally depends on out_ready); 1 = main slot plus skid slot (in_ready registered).
- CNT_W, 16, width of the stall counter.

Ports:
- CLK  in  1  clock; all state updates on the falling edge, consistent with the rest of the pipeline.
- RST  in  1  synchronous, active-high reset, sampled on the same falling edge.
- flush  in  1  kill the contents of this stage (branch/jump redirect).
- in_valid  in  1  upstream holds a real instruction.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  stage presents a real instruction.
- out_ready  in  1  downstream accepts this cycle (0 = stall).
- out_data  out  DATA_W  data payload, NOP_DATA when !out_valid.
- out_ctrl  out  CTRL_W  control payload, NOP_CTRL when !out_valid.
- out_bubble  out  1  equals !out_valid.
- NEW  out  1  high from reset until the first accepted input.
- occupancy  out  2  number of held entries, 0..2 (max 1 when SKID=0).
- stall_cnt  out  CNT_W  saturating count of cycles with in_valid && !in_ready.

Behaviour:
- Reset: on a falling edge with RST=1, all of the following hold; RST has priority over every other input.
  - out_valid=0, out_data=NOP_DATA, out_ctrl=NOP_CTRL, out_bubble=1.
  - Skid slot empty, occupancy=0, NEW=1, stall_cnt=0.
  - in_ready=1 in the cycle after reset.
- Transfers: acc_in = in_valid && in_ready; acc_out = out_valid && out_ready.
- Latency: one edge from acc_in to out_valid when the main slot is empty or draining. Full throughput is 1 per cycle.
- SKID=0: in_ready = !out_valid || out_ready (combinational).
  - On acc_in the main slot loads in_*.
  - On acc_out without acc_in, out_valid goes to 0 and the outputs return to NOP values.
- SKID=1: in_ready = !skid_valid (registered only).
  - Main empty and acc_in: load main.
  - Main full, out_ready=1, skid empty and acc_in: main loads in_* (pass-through).
  - Main full, out_ready=0 and acc_in: in_* goes to the skid slot.
  - acc_out with skid full: skid moves to main and skid empties. in_ready was 0, so no acc_in can occur that cycle.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- Flush (RST=0): both slots are cleared to NOP and occupancy becomes 0.
  - acc_in in the flush cycle is discarded; the younger instruction is killed.
  - acc_out in the flush cycle is still valid, since downstream already sampled it.
  - in_ready behaves as normal during flush.
- NEW clears on the first acc_in after reset, including one discarded by flush. It never re-asserts except via RST.
- stall_cnt increments by 1 each cycle in_valid && !in_ready, saturating at 2^CNT_W-1. Flush does not clear it.
- occupancy updates on the same edge as the slots. It never exceeds 1+SKID.
- Holding a stall: the outputs stay bit-stable while out_valid && !out_ready.

Decomposition:
- Shared package pipe_pkg:
  - NOP_INSTR = 32'h13.
  - Control-word field offsets and widths (ALUsrcA, ALUsrcB, WBSel, ImmSel, MemWrEn, RegWrEn, LoadType, MemSize, halt).
  - Stage NOP_CTRL constants.
- One natural sub-module: pipe_slot, a single payload+valid register with load/clear. Instantiated once for main, and once more for skid when SKID=1.

Test Plan:
- Reset and fill: RST=1 for 2 edges, then in_valid=1, in_data=32'h00A00093, out_ready=1 → after reset out_data=32'h13, occupancy=0, NEW=1; one edge later out_valid=1, out_data=32'h00A00093, NEW=0.
- Skid absorb (SKID=1): stream 32'h1,2,3 with out_ready=0 from cycle 1 → occupancy=2, in_ready=0, stall_cnt counts 1 per cycle; release out_ready → outputs 1,2,3 in order with no gap.
- Single slot (SKID=0): out_ready=0 with main full → in_ready=0 in the same cycle; out_ready=1 with in_valid=1 → back-to-back transfer with occupancy staying 1.
- Flush with skid full: occupancy=2, flush=1, in_valid=1 → next edge out_valid=0, out_data=32'h13, out_ctrl=NOP_CTRL, occupancy=0; the input is not observed later.
- Reset mid-operation: occupancy=2, stall_cnt=5, RST=1 for one edge → all outputs at reset values, NEW=1, stall_cnt=0.
- Counter saturation: CNT_W=3, hold in_valid=1 and out_ready=0 for 12 cycles → stall_cnt stops at 7.
